sram_1rw_port_arbiter: RTL and testbench

//  Shares one single-port 1RW SRAM macro (1 op/cycle, 1-cycle registered-address read, per-segment write mask)

---
 rtl/sram_arb_pkg.sv | 8 +
 rtl/sram_resp_skid.sv | 35 +++
 rtl/sram_1rw_port_arbiter.sv | 64 ++++++
 tb/tb_sram_1rw_port_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: default geometry and op encoding shared by the 1RW SRAM port arbiter.
package sram_arb_pkg;
  localparam int ADDR_W_D = 1;
  localparam int DATA_W_D = 96;
  localparam int MASK_W_D = 2;
  localparam int STARVE_LIMIT_D = 4;
  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;
endpackage

// File: rtl/sram_resp_skid.sv
// sram_resp_skid: one-entry skid holding a read response the consumer has not yet taken.
module sram_resp_skid #(
  parameter int DATA_W = 96
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_grant,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              resp_ready,
  output logic              rd_ok,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);
  logic              inflight_q, skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  // Capture the macro output the cycle after the read, since a following write may disturb it.
  always_comb begin
    skid_v_d = skid_v_q ? !resp_ready : (inflight_q && !resp_ready);
    skid_d   = (inflight_q && !skid_v_q && !resp_ready) ? sram_rdata : skid_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      skid_v_q   <= 1'b0;
      skid_q     <= '0;
    end else begin
      inflight_q <= rd_grant;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
    end
  end
  assign rd_ok      = !skid_v_q && (!inflight_q || resp_ready);
  assign resp_valid = skid_v_q || inflight_q;
  assign resp_data  = skid_v_q ? skid_q : sram_rdata;
endmodule

// File: rtl/sram_1rw_port_arbiter.sv
// sram_1rw_port_arbiter: shares one 1RW SRAM between a write and a read channel,
// one op per cycle, with a skid-buffered read response and bounded write starvation.
module sram_1rw_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_D,
  parameter int DATA_W       = DATA_W_D,
  parameter int MASK_W       = MASK_W_D,
  parameter int STARVE_LIMIT = STARVE_LIMIT_D
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_ok, force_w, rd_grant, wr_grant;
  op_e           op;
  sram_resp_skid #(.DATA_W(DATA_W)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .rd_grant   (rd_grant),
    .sram_rdata (sram_rdata),
    .resp_ready (resp_ready),
    .rd_ok      (rd_ok),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );
  // Reads win by default; a write that has lost STARVE_LIMIT times in a row takes the slot.
  assign force_w  = starve_q == SW'(STARVE_LIMIT);
  assign r_ready  = rd_ok && !(w_valid && force_w);
  assign w_ready  = force_w || !(r_valid && rd_ok);
  assign rd_grant = r_valid && r_ready;
  assign wr_grant = w_valid && w_ready;
  assign op       = rd_grant ? OP_RD : (wr_grant ? OP_WR : OP_IDLE);
  always_comb begin
    sram_en    = op != OP_IDLE;
    sram_wmode = op == OP_WR;
    sram_addr  = op == OP_RD ? r_addr : (op == OP_WR ? w_addr : '0);
    sram_wmask = op == OP_WR ? w_mask : '0;
    sram_wdata = op == OP_WR ? w_data : '0;
    starve_d   = (w_valid && !w_ready) ? (force_w ? starve_q : starve_q + 1'b1) : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
endmodule

// File: tb/tb_sram_1rw_port_arbiter.sv
// tb_sram_1rw_port_arbiter: arbiter paired with a 2x96b 2-segment 1RW macro model,
// checked each cycle against a response-queue reference model.
module tb_sram_1rw_port_arbiter;
  localparam int AW = 1, DW = 96, MW = 2, LIM = 4, SEG = DW / MW;
  localparam logic [DW-1:0] VA = {24{4'hA}};
  localparam logic [DW-1:0] VB = {24{4'hB}};
  logic clock = 1'b0, reset;
  logic w_valid, w_ready, r_valid, r_ready, resp_valid, resp_ready, sram_en, sram_wmode;
  logic [AW-1:0] w_addr, r_addr, sram_addr;
  logic [MW-1:0] w_mask, sram_wmask;
  logic [DW-1:0] w_data, resp_data, sram_wdata, sram_rdata;
  always #5 clock = ~clock;
  sram_1rw_port_arbiter dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  logic [DW-1:0] mem [2];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < MW; s++)
          if (sram_wmask[s]) mem[sram_addr][s*SEG +: SEG] <= sram_wdata[s*SEG +: SEG];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end
  logic [DW-1:0] ref_mem [2];
  logic [DW-1:0] q_d [$];
  int q_s [$];
  int cyc = 0, starve_m = 0, errors = 0, checks = 0, dr = 0, dw = 0;
  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic rok, frc, er, ew, rg, wg, ev;
    @(negedge clock);
    ev  = q_d.size() > 0;
    rok = q_d.size() == 0 || (q_d.size() == 1 && q_s[0] == cyc - 1 && resp_ready);
    frc = starve_m == LIM;
    er  = rok && !(w_valid && frc);
    ew  = frc || !(r_valid && rok);
    rg  = r_valid && er;
    wg  = w_valid && ew;
    chkb("r_ready", r_ready, er);
    chkb("w_ready", w_ready, ew);
    chkb("resp_valid", resp_valid, ev);
    if (ev) chkd("resp_data", resp_data, q_d[0]);
    chkb("sram_en", sram_en, rg || wg);
    chkb("both_grant", r_valid && r_ready && w_valid && w_ready, 1'b0);
    if (rg) begin
      chkb("rd_wmode", sram_wmode, 1'b0);
      chkd("rd_addr", DW'(sram_addr), DW'(r_addr));
    end
    if (wg) begin
      chkb("wr_wmode", sram_wmode, 1'b1);
      chkd("wr_addr", DW'(sram_addr), DW'(w_addr));
      chkd("wr_mask", DW'(sram_wmask), DW'(w_mask));
      chkd("wr_data", sram_wdata, w_data);
    end
    if (r_valid && r_ready) dr++;
    if (w_valid && w_ready) dw++;
    @(posedge clock);
    if (ev && resp_ready) begin
      void'(q_d.pop_front());
      void'(q_s.pop_front());
    end
    if (rg) begin
      q_d.push_back(ref_mem[r_addr]);
      q_s.push_back(cyc);
    end
    if (wg)
      for (int s = 0; s < MW; s++)
        if (w_mask[s]) ref_mem[w_addr][s*SEG +: SEG] = w_data[s*SEG +: SEG];
    starve_m = (w_valid && !ew) ? ((starve_m + 1 > LIM) ? LIM : starve_m + 1) : 0;
    cyc++;
    #1;
  endtask
  initial begin
    reset = 1'b1; w_valid = 0; r_valid = 0; resp_ready = 1;
    w_addr = 0; r_addr = 0; w_mask = 0; w_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chkb("rst_resp_valid", resp_valid, 1'b0);
    chkb("rst_sram_en", sram_en, 1'b0);
    reset = 1'b0;
    // write A to addr0, read it back
    w_valid = 1; w_addr = 0; w_mask = 2'b11; w_data = VA;
    step();
    w_valid = 0; r_valid = 1; r_addr = 0;
    step();
    r_valid = 0;
    chkb("t1_valid", resp_valid, 1'b1);
    chkd("t1_data", resp_data, VA);
    step();
    // partial-mask overwrite of addr1
    w_valid = 1; w_addr = 1; w_mask = 2'b11; w_data = '1;
    step();
    w_mask = 2'b01; w_data = '0;
    step();
    w_valid = 0; r_valid = 1; r_addr = 1;
    step();
    r_valid = 0;
    chkd("t2_data", resp_data, {{SEG{1'b1}}, {SEG{1'b0}}});
    step();
    // sustained contention: 4 reads then a forced write
    dr = 0; dw = 0;
    r_valid = 1; w_valid = 1; r_addr = 1; w_addr = 1; w_mask = 2'b11; w_data = '1;
    repeat (15) step();
    chkd("t3_reads", DW'(dr), DW'(12));
    chkd("t3_writes", DW'(dw), DW'(3));
    r_valid = 0; w_valid = 0;
    step();
    // stalled response survives a later write to the same address
    r_valid = 1; r_addr = 0; resp_ready = 0;
    step();
    r_valid = 0; w_valid = 1; w_addr = 0; w_mask = 2'b11; w_data = VB;
    dw = 0;
    step();
    w_valid = 0; r_valid = 1;
    #1;
    chkd("t4_hold", resp_data, VA);
    chkb("t4_rblock", r_ready, 1'b0);
    chkd("t4_wgrant", DW'(dw), DW'(1));
    step();
    chkd("t4_hold2", resp_data, VA);
    resp_ready = 1;
    step();
    r_valid = 0;
    step();
    // reads every cycle with toggling consumer
    r_valid = 1;
    for (int i = 0; i < 40; i++) begin
      r_addr = AW'($urandom_range(0, 1));
      resp_ready = i[0];
      step();
    end
    r_valid = 0; resp_ready = 1;
    repeat (3) step();
    // reset with a stalled response and non-zero starvation
    r_valid = 1; w_valid = 1; r_addr = 0; w_addr = 1; w_mask = 2'b10; w_data = VB;
    step(); step();
    r_valid = 0; w_valid = 0; resp_ready = 0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chkb("t6_resp_valid", resp_valid, 1'b0);
    chkb("t6_sram_en", sram_en, 1'b0);
    q_d.delete(); q_s.delete(); starve_m = 0;
    @(posedge clock);
    cyc++;
    #1;
    reset = 1'b0;
    r_valid = 1; w_valid = 1; resp_ready = 1; dr = 0; dw = 0;
    repeat (5) step();
    chkd("t6_reads", DW'(dr), DW'(4));
    chkd("t6_writes", DW'(dw), DW'(1));
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_valid = 1'($urandom); w_valid = 1'($urandom); resp_ready = ($urandom_range(0, 3) != 0);
      r_addr = AW'($urandom); w_addr = AW'($urandom); w_mask = MW'($urandom);
      w_data = {$urandom, $urandom, $urandom};
      step();
    end
    r_valid = 0; w_valid = 0; resp_ready = 1;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
